fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port pc_cur  in  16  current PC from PC register output.
REQ-004 SHALL have port stall  in  1  hazard-unit stall request.
REQ-005 SHALL have port br_taken  in  1  branch/jump resolved taken this cycle.
REQ-006 SHALL have port br_target  in  16  redirect address, valid with br_taken.
REQ-007 SHALL have port halt_dec  in  1  HLT decoded in fetch stage.
REQ-008 SHALL have port icache_miss  in  1  I-cache miss on pc_cur this cycle.
REQ-009 SHALL have port fill_done  in  1  I-cache fill complete; pulse.
REQ-010 SHALL have ports pc_next (out, 16, PC register D input) and pc_en (out, 1, PC register write enable).
REQ-011 SHALL have ports ifid_en (out, 1, IF/ID write), ifid_flush (out, 1, squash IF/ID), fetch_valid (out, 1, fetched instruction usable), halted (out, 1, core halted).

Function
REQ-012 SHALL implement FSM states RUN, MISS, HALT.
REQ-013 SHALL compute sequential PC as pc_cur + 2, modulo 2^16 (16'hFFFE -> 16'h0000), no carry out.
REQ-014 SHALL, in RUN, use priority br_taken > icache_miss > stall > halt_dec > sequential.
REQ-015 SHALL, in RUN with br_taken, drive pc_next=br_target, pc_en=1, ifid_flush=1, fetch_valid=0 in the same cycle, regardless of stall or miss.
REQ-016 SHALL, in RUN with icache_miss and no br_taken, drive pc_en=0, fetch_valid=0, ifid_en=0, and enter MISS next cycle.
REQ-017 SHALL, in RUN with stall only, drive pc_en=0 and ifid_en=0; fetch_valid=1.
REQ-018 SHALL, in RUN with halt_dec only, drive pc_en=0, fetch_valid=1, and enter HALT next cycle.
REQ-019 SHALL, in RUN with no event, drive pc_next=pc_cur+2, pc_en=1, ifid_en=1, fetch_valid=1.
REQ-020 SHALL, in MISS, hold pc_en=0, ifid_en=0, fetch_valid=0.
REQ-021 SHALL, on br_taken in MISS, latch br_target into a pending-redirect register, set pending flag, and pulse ifid_flush=1; a later br_taken overwrites the target.
REQ-022 SHALL, on fill_done in MISS with no pending redirect, return to RUN with fetch_valid=1 and pc_en per REQ-017/REQ-019.
REQ-023 SHALL, on fill_done in MISS with pending (or br_taken same cycle), drive pc_next=latest target, pc_en=1, fetch_valid=0, clear pending, and return to RUN.
REQ-024 SHALL, in HALT, assert halted=1 and pc_en=0; br_taken in HALT drives pc_next=br_target, pc_en=1, ifid_flush=1, and returns to RUN.
REQ-025 SHALL produce all outputs combinationally from state and inputs; no added pipeline latency.

Reset
REQ-026 SHALL, while rst_n=0, force state=RUN, pending=0, and pc_en, ifid_en, ifid_flush, fetch_valid, halted all 0; pc_next=16'h0000.
REQ-027 SHALL abandon any MISS or pending redirect on reset assertion mid-operation.

Configuration
REQ-028 SHALL, with FETCH_STAT_EN defined, add outputs miss_cycles[15:0] and redirect_cnt[15:0]: saturating counters of cycles spent in MISS and of br_taken redirects applied, cleared by reset.
REQ-029 SHALL, without FETCH_STAT_EN, omit the counters and their ports entirely.

Structure
REQ-030 SHALL place the FSM state enum, PC_RESET (16'h0000), and PC_INC (16'd2) in the shared cpu_pkg package.
REQ-031 SHALL use one sub-module, redirect_hold, containing the pending-redirect target register and flag.

Verification
REQ-032 SHALL cover: reset release, pc_cur=0000, no events -> pc_next=0002, pc_en=1, fetch_valid=1.
REQ-033 SHALL cover: pc_cur=FFFE, no events -> pc_next=0000.
REQ-034 SHALL cover: stall=1 and br_taken=1, br_target=0040 in the same cycle -> pc_next=0040, pc_en=1, ifid_flush=1.
REQ-035 SHALL cover: icache_miss at pc 0010; br_taken target 0080 during MISS, then fill_done 3 cycles later -> pc_next=0080, pc_en=1, fetch_valid=0, state RUN.
REQ-036 SHALL cover: halt_dec at pc 0020 -> halted=1 next cycle, pc_en=0; then br_taken target 0100 -> pc_next=0100, halted=0 next cycle.
REQ-037 SHALL cover: rst_n asserted during MISS with pending set -> state RUN, pending=0, all outputs 0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states and PC constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MISS = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [15:0] PC_RESET = 16'h0000;
    localparam logic [15:0] PC_INC   = 16'd2;

endpackage

// File: rtl/redirect_hold.sv
// Pending-redirect holder: remembers a branch target that resolved while
// the fetch stage was waiting on an I-cache fill.
module redirect_hold
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_set,
    input  logic        hold_clr,
    input  logic [15:0] tgt_in,
    output logic        pend_flag,
    output logic [15:0] pend_tgt
);

    // Pending flag: clear wins over set so a redirect consumed in the same
    // cycle it arrives leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_flag <= 1'b0;
        end else if (hold_clr) begin
            pend_flag <= 1'b0;
        end else if (hold_set) begin
            pend_flag <= 1'b1;
        end
    end

    // Target register; only meaningful while pend_flag is set, so no reset.
    // A later branch simply overwrites the earlier target.
    always_ff @(posedge clk) begin
        if (hold_set) begin
            pend_tgt <= tgt_in;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: next-PC selection, IF/ID control, I-cache miss
// waiting and halt handling. All outputs are combinational from state and
// inputs. Optional statistics counters are enabled by defining FETCH_STAT_EN.
module fetch_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc_cur,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    input  logic        halt_dec,
    input  logic        icache_miss,
    input  logic        fill_done,
    output logic [15:0] pc_next,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        fetch_valid,
`ifdef FETCH_STAT_EN
    output logic [15:0] miss_cycles,
    output logic [15:0] redirect_cnt,
`endif
    output logic        halted
);

    fetch_state_t state, state_nx;
    logic [15:0]  pc_seq;
    logic         hold_set, hold_clr, redir_apply;
    logic         pend_flag;
    logic [15:0]  pend_tgt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Sequential PC wraps naturally at 16 bits.
    assign pc_seq = pc_cur + PC_INC;

    redirect_hold u_redirect_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold_set  (hold_set),
        .hold_clr  (hold_clr),
        .tgt_in    (br_target),
        .pend_flag (pend_flag),
        .pend_tgt  (pend_tgt)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and output decode; reset forces every output low.
    always_comb begin
        state_nx    = state;
        pc_next     = pc_seq;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        fetch_valid = 1'b0;
        halted      = 1'b0;
        hold_set    = 1'b0;
        hold_clr    = 1'b0;
        redir_apply = 1'b0;
        case (state)
            RUN: begin
                if (br_taken) begin
                    pc_next     = br_target;
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    ifid_flush  = 1'b1;
                    redir_apply = 1'b1;
                end else if (icache_miss) begin
                    state_nx = MISS;
                end else if (stall) begin
                    fetch_valid = 1'b1;
                end else if (halt_dec) begin
                    fetch_valid = 1'b1;
                    state_nx    = HALT;
                end else begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    fetch_valid = 1'b1;
                end
            end
            MISS: begin
                if (fill_done) begin
                    state_nx = RUN;
                    if (pend_flag || br_taken) begin
                        pc_next     = br_taken ? br_target : pend_tgt;
                        pc_en       = 1'b1;
                        ifid_flush  = 1'b1;
                        hold_clr    = 1'b1;
                        redir_apply = 1'b1;
                    end else begin
                        fetch_valid = 1'b1;
                        pc_en       = !stall;
                        ifid_en     = !stall;
                    end
                end else if (br_taken) begin
                    hold_set   = 1'b1;
                    ifid_flush = 1'b1;
                end
            end
            HALT: begin
                halted = 1'b1;
                if (br_taken) begin
                    pc_next     = br_target;
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    ifid_flush  = 1'b1;
                    redir_apply = 1'b1;
                    state_nx    = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
        if (!rst_n) begin
            state_nx    = RUN;
            pc_next     = PC_RESET;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b0;
            fetch_valid = 1'b0;
            halted      = 1'b0;
            hold_set    = 1'b0;
            hold_clr    = 1'b0;
            redir_apply = 1'b0;
        end
    end

`ifdef FETCH_STAT_EN
    // Saturating counters of MISS cycles and applied redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cycles  <= 16'h0000;
            redirect_cnt <= 16'h0000;
        end else begin
            if (state == MISS) begin
                miss_cycles <= sat_inc16(miss_cycles);
            end
            if (redir_apply) begin
                redirect_cnt <= sat_inc16(redirect_cnt);
            end
        end
    end
`else
    logic unused_stat;
    assign unused_stat = redir_apply & (sat_inc16(16'h0000) == 16'h0001);
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc_cur;
    logic        stall, br_taken, halt_dec, icache_miss, fill_done;
    logic [15:0] br_target;
    logic [15:0] pc_next;
    logic        pc_en, ifid_en, ifid_flush, fetch_valid, halted;
`ifdef FETCH_STAT_EN
    logic [15:0] miss_cycles, redirect_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_cur      (pc_cur),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .halt_dec    (halt_dec),
        .icache_miss (icache_miss),
        .fill_done   (fill_done),
        .pc_next     (pc_next),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .fetch_valid (fetch_valid),
`ifdef FETCH_STAT_EN
        .miss_cycles (miss_cycles),
        .redirect_cnt(redirect_cnt),
`endif
        .halted      (halted)
    );

    task automatic idle_inputs();
        stall = 0; br_taken = 0; br_target = 16'h0000;
        halt_dec = 0; icache_miss = 0; fill_done = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; pc_cur = 16'h1234; idle_inputs();
        #2;
        checks++; if ({pc_en, ifid_en, ifid_flush, fetch_valid, halted} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 00000", {pc_en, ifid_en, ifid_flush, fetch_valid, halted}); end
        checks++; if (pc_next !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", pc_next); end
        next_cycle();
        checks++; if (dut.state !== RUN || dut.pend_flag !== 1'b0) begin errors++; $display("FAIL reset_state state=%0d pend=%b exp 0/0", dut.state, dut.pend_flag); end
        #3 rst_n = 1;
        next_cycle();
    endtask

    task automatic test_sequential();
        idle_inputs(); pc_cur = 16'h0000; #1;
        checks++; if (pc_next !== 16'h0002 || pc_en !== 1 || fetch_valid !== 1 || ifid_en !== 1) begin errors++; $display("FAIL seq_0 pc_next=%h en=%b fv=%b ifid=%b exp 0002/1/1/1", pc_next, pc_en, fetch_valid, ifid_en); end
        next_cycle();
        pc_cur = 16'hFFFE; #1;
        checks++; if (pc_next !== 16'h0000 || pc_en !== 1) begin errors++; $display("FAIL seq_wrap pc_next=%h en=%b exp 0000/1", pc_next, pc_en); end
        next_cycle();
    endtask

    task automatic test_stall_branch();
        idle_inputs(); pc_cur = 16'h0004; stall = 1; #1;
        checks++; if (pc_en !== 0 || ifid_en !== 0 || fetch_valid !== 1 || ifid_flush !== 0) begin errors++; $display("FAIL stall_only en=%b ifid=%b fv=%b fl=%b exp 0/0/1/0", pc_en, ifid_en, fetch_valid, ifid_flush); end
        br_taken = 1; br_target = 16'h0040; #1;
        checks++; if (pc_next !== 16'h0040 || pc_en !== 1 || ifid_flush !== 1 || fetch_valid !== 0) begin errors++; $display("FAIL stall_br pc_next=%h en=%b fl=%b fv=%b exp 0040/1/1/0", pc_next, pc_en, ifid_flush, fetch_valid); end
        icache_miss = 1; #1;
        checks++; if (pc_next !== 16'h0040 || pc_en !== 1 || ifid_flush !== 1) begin errors++; $display("FAIL miss_br pc_next=%h en=%b fl=%b exp 0040/1/1", pc_next, pc_en, ifid_flush); end
        next_cycle();
        checks++; if (dut.state !== RUN) begin errors++; $display("FAIL br_stays_run state=%0d exp 0", dut.state); end
        idle_inputs();
    endtask

    task automatic test_miss_redirect();
        idle_inputs(); pc_cur = 16'h0010; icache_miss = 1; #1;
        checks++; if (pc_en !== 0 || fetch_valid !== 0 || ifid_en !== 0) begin errors++; $display("FAIL miss_entry en=%b fv=%b ifid=%b exp 0/0/0", pc_en, fetch_valid, ifid_en); end
        next_cycle();
        icache_miss = 0;
        checks++; if (dut.state !== MISS) begin errors++; $display("FAIL miss_state state=%0d exp 1", dut.state); end
        br_taken = 1; br_target = 16'h0080; #1;
        checks++; if (ifid_flush !== 1 || pc_en !== 0 || fetch_valid !== 0) begin errors++; $display("FAIL miss_br fl=%b en=%b fv=%b exp 1/0/0", ifid_flush, pc_en, fetch_valid); end
        next_cycle();
        br_taken = 0; br_target = 16'h0000; #1;
        checks++; if (dut.pend_flag !== 1 || pc_en !== 0 || ifid_flush !== 0) begin errors++; $display("FAIL miss_pend pend=%b en=%b fl=%b exp 1/0/0", dut.pend_flag, pc_en, ifid_flush); end
        next_cycle();
        next_cycle();
        fill_done = 1; #1;
        checks++; if (pc_next !== 16'h0080 || pc_en !== 1 || fetch_valid !== 0) begin errors++; $display("FAIL fill_redir pc_next=%h en=%b fv=%b exp 0080/1/0", pc_next, pc_en, fetch_valid); end
        next_cycle();
        fill_done = 0; #1;
        checks++; if (dut.state !== RUN || dut.pend_flag !== 0) begin errors++; $display("FAIL fill_return state=%0d pend=%b exp 0/0", dut.state, dut.pend_flag); end
    endtask

    task automatic test_miss_plain();
        idle_inputs(); pc_cur = 16'h0030; icache_miss = 1;
        next_cycle();
        icache_miss = 0; fill_done = 1; #1;
        checks++; if (pc_next !== 16'h0032 || pc_en !== 1 || fetch_valid !== 1 || ifid_en !== 1) begin errors++; $display("FAIL fill_plain pc_next=%h en=%b fv=%b ifid=%b exp 0032/1/1/1", pc_next, pc_en, fetch_valid, ifid_en); end
        next_cycle();
        fill_done = 0; #1;
        checks++; if (dut.state !== RUN) begin errors++; $display("FAIL fill_plain_state state=%0d exp 0", dut.state); end
    endtask

    task automatic test_halt();
        idle_inputs(); pc_cur = 16'h0020; halt_dec = 1; #1;
        checks++; if (pc_en !== 0 || fetch_valid !== 1 || halted !== 0) begin errors++; $display("FAIL halt_dec en=%b fv=%b halted=%b exp 0/1/0", pc_en, fetch_valid, halted); end
        next_cycle();
        halt_dec = 0; #1;
        checks++; if (halted !== 1 || pc_en !== 0) begin errors++; $display("FAIL halt_state halted=%b en=%b exp 1/0", halted, pc_en); end
        next_cycle();
        checks++; if (halted !== 1) begin errors++; $display("FAIL halt_hold halted=%b exp 1", halted); end
        br_taken = 1; br_target = 16'h0100; #1;
        checks++; if (pc_next !== 16'h0100 || pc_en !== 1 || ifid_flush !== 1) begin errors++; $display("FAIL halt_br pc_next=%h en=%b fl=%b exp 0100/1/1", pc_next, pc_en, ifid_flush); end
        next_cycle();
        idle_inputs(); #1;
        checks++; if (halted !== 0 || dut.state !== RUN) begin errors++; $display("FAIL halt_exit halted=%b state=%0d exp 0/0", halted, dut.state); end
    endtask

    task automatic test_reset_mid_miss();
        idle_inputs(); pc_cur = 16'h0050; icache_miss = 1;
        next_cycle();
        icache_miss = 0; br_taken = 1; br_target = 16'h0090;
        next_cycle();
        br_taken = 0; #1;
        checks++; if (dut.state !== MISS || dut.pend_flag !== 1) begin errors++; $display("FAIL pre_reset state=%0d pend=%b exp 1/1", dut.state, dut.pend_flag); end
        fill_done = 1; stall = 1;
        rst_n = 0; #1;
        checks++; if (dut.state !== RUN || dut.pend_flag !== 0) begin errors++; $display("FAIL midreset_state state=%0d pend=%b exp 0/0", dut.state, dut.pend_flag); end
        checks++; if ({pc_en, ifid_en, ifid_flush, fetch_valid, halted} !== 5'b0 || pc_next !== 16'h0000) begin errors++; $display("FAIL midreset_out ctrl=%b pc_next=%h exp 00000/0000", {pc_en, ifid_en, ifid_flush, fetch_valid, halted}, pc_next); end
        idle_inputs();
        next_cycle();
        #3 rst_n = 1;
        next_cycle();
        pc_cur = 16'h0060; #1;
        checks++; if (pc_next !== 16'h0062 || pc_en !== 1 || fetch_valid !== 1) begin errors++; $display("FAIL post_reset pc_next=%h en=%b fv=%b exp 0062/1/1", pc_next, pc_en, fetch_valid); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_branch();
        test_miss_redirect();
        test_miss_plain();
        test_halt();
        test_reset_mid_miss();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
